// File: rtl/bus_arbiter.sv
// Round-robin sequencer for the shared operand bus mux: one-hot grants, registered select/data/valid,
// one-cycle turnaround between owners. Optional grant-timeout feature: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1,
    input  logic             req2,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    input  logic             fill_ones,
    output logic             gnt1,
    output logic             gnt2,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] bus_data,
`ifdef BUS_ARB_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic             bus_valid
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arbiter: MAX_HOLD must lie in 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT1 = 2'd1,
        S_GRANT2 = 2'd2,
        S_TURN   = 2'd3
    } state_e;

    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_IN1  = 2'b01;
    localparam logic [1:0] SEL_IN2  = 2'b10;
    localparam logic [1:0] SEL_ONES = 2'b11;

    // last_owner: 0 = requester 1 held the bus last, 1 = requester 2 did.
    state_e           state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic             gnt1_q, gnt1_d;
    logic             gnt2_q, gnt2_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] bus_data_q, bus_data_d;
    logic             bus_valid_q, bus_valid_d;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    // Tie goes to whoever did not own the bus most recently.
    function automatic state_e arbitrate(input logic r1, input logic r2, input logic last2);
        state_e nxt;
        nxt = S_IDLE;
        if (r1 && r2) begin
            nxt = last2 ? S_GRANT1 : S_GRANT2;
        end else if (r1) begin
            nxt = S_GRANT1;
        end else if (r2) begin
            nxt = S_GRANT2;
        end
        return nxt;
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        last_owner_d = last_owner_q;
`ifdef BUS_ARB_TIMEOUT_EN
        timeout_d    = 1'b0;
        hold_cnt_d   = hold_cnt_q;
`endif

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_TURN: state_d = arbitrate(req1, req2, last_owner_q);
                S_GRANT1: begin
                    if (!req1) begin
                        state_d      = S_TURN;
                        last_owner_d = 1'b0;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (req2 && hold_cnt_q == HOLD_LAST) begin
                        state_d      = S_TURN;
                        last_owner_d = 1'b0;
                        timeout_d    = 1'b1;
                    end
`endif
                end
                S_GRANT2: begin
                    if (!req2) begin
                        state_d      = S_TURN;
                        last_owner_d = 1'b1;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (req1 && hold_cnt_q == HOLD_LAST) begin
                        state_d      = S_TURN;
                        last_owner_d = 1'b1;
                        timeout_d    = 1'b1;
                    end
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef BUS_ARB_TIMEOUT_EN
        // An owner change always passes through TURN, so equal grant states mean the same tenure.
        if (state_d == S_GRANT1 || state_d == S_GRANT2) begin
            if (state_d != state_q) begin
                hold_cnt_d = 8'd0;
            end else if (hold_cnt_q != HOLD_LAST) begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
        end
`endif
    end

    // Registered outputs are decoded from the next state so gnt, sel and bus_data move together.
    always_comb begin
        gnt1_d      = 1'b0;
        gnt2_d      = 1'b0;
        bus_valid_d = 1'b0;
        sel_d       = SEL_ZERO;

        case (state_d)
            S_GRANT1: begin
                gnt1_d      = 1'b1;
                bus_valid_d = 1'b1;
                sel_d       = SEL_IN1;
            end
            S_GRANT2: begin
                gnt2_d      = 1'b1;
                bus_valid_d = 1'b1;
                sel_d       = SEL_IN2;
            end
            S_IDLE:  sel_d = (fill_ones && !flush) ? SEL_ONES : SEL_ZERO;
            default: sel_d = SEL_ZERO;
        endcase

        case (sel_d)
            SEL_IN1:  bus_data_d = in1;
            SEL_IN2:  bus_data_d = in2;
            SEL_ONES: bus_data_d = '1;
            default:  bus_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b1;
            gnt1_q       <= 1'b0;
            gnt2_q       <= 1'b0;
            sel_q        <= SEL_ZERO;
            bus_data_q   <= '0;
            bus_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            gnt1_q       <= gnt1_d;
            gnt2_q       <= gnt2_d;
            sel_q        <= sel_d;
            bus_data_q   <= bus_data_d;
            bus_valid_q  <= bus_valid_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign gnt1      = gnt1_q;
    assign gnt2      = gnt2_q;
    assign sel       = sel_q;
    assign bus_data  = bus_data_q;
    assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus random traffic against an owner/turn model.
// Also builds with BUS_ARB_TIMEOUT_EN defined, in which case the timeout output is modelled too.
module tb_bus_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req1 = 1'b0;
    logic             req2 = 1'b0;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic             flush = 1'b0;
    logic             fill_ones = 1'b0;
    logic             gnt1;
    logic             gnt2;
    logic [1:0]       sel;
    logic [WIDTH-1:0] bus_data;
    logic             bus_valid;
    logic             timeout_obs;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
    logic timeout;
    assign timeout_obs = timeout;
`else
    localparam bit TIMEOUT_ON = 1'b0;
    assign timeout_obs = 1'b0;
`endif

    bus_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req1      (req1),
        .req2      (req2),
        .in1       (in1),
        .in2       (in2),
        .flush     (flush),
        .fill_ones (fill_ones),
        .gnt1      (gnt1),
        .gnt2      (gnt2),
        .sel       (sel),
        .bus_data  (bus_data),
`ifdef BUS_ARB_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .bus_valid (bus_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             gnt1;
        logic             gnt2;
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
        logic             valid;
        logic             timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: who owns the bus, whether we sit in the turnaround cycle, who owned it last,
    // and how many cycles the current owner has held it.
    int m_owner = 0;
    bit m_turn  = 1'b0;
    int m_last  = 2;
    int m_held  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit fo, input bit q1, input bit q2,
                        input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
        exp_t e;
        bit   to;
        bit   mine;
        bit   other;
        @(negedge clk);
        rst = r; flush = f; fill_ones = fo; req1 = q1; req2 = q2; in1 = d1; in2 = d2;

        to = 1'b0;
        if (r) begin
            m_owner = 0; m_turn = 1'b0; m_last = 2; m_held = 0;
        end else if (f) begin
            m_owner = 0; m_turn = 1'b0;
        end else if (m_owner != 0) begin
            mine  = (m_owner == 1) ? q1 : q2;
            other = (m_owner == 1) ? q2 : q1;
            if (!mine || (TIMEOUT_ON && other && m_held == MAX_HOLD)) begin
                to      = mine;
                m_last  = m_owner;
                m_owner = 0;
                m_turn  = 1'b1;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else begin
            m_turn = 1'b0;
            if (q1 && q2)  m_owner = 3 - m_last;
            else if (q1)   m_owner = 1;
            else if (q2)   m_owner = 2;
            else           m_owner = 0;
            if (m_owner != 0) m_held = 1;
        end

        e.gnt1    = (m_owner == 1);
        e.gnt2    = (m_owner == 2);
        e.valid   = (m_owner != 0);
        e.timeout = to;
        if (m_owner == 1)                              e.sel = 2'b01;
        else if (m_owner == 2)                         e.sel = 2'b10;
        else if (!r && !f && !m_turn && fo)            e.sel = 2'b11;
        else                                           e.sel = 2'b00;
        case (e.sel)
            2'b01:   e.data = d1;
            2'b10:   e.data = d2;
            2'b11:   e.data = '1;
            default: e.data = '0;
        endcase
        exp_q.push_back(e);

        @(posedge clk);
        #2;
    endtask

    // Monitor: the DUT presents a bus word every cycle; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt1",      32'(gnt1),        32'(e.gnt1));
                check("gnt2",      32'(gnt2),        32'(e.gnt2));
                check("sel",       32'(sel),         32'(e.sel));
                check("bus_data",  32'(bus_data),    32'(e.data));
                check("bus_valid", 32'(bus_valid),   32'(e.valid));
                check("timeout",   32'(timeout_obs), 32'(e.timeout));
                check("one_hot",   32'(gnt1 & gnt2), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit r, f, fo, q1, q2;

        // Reset and first grant.
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        check("reset_sel", 32'(sel), 32'd0);
        step(0, 0, 0, 1, 0, 8'hA5, 8'h00);
        check("first_gnt1", 32'(gnt1), 32'd1);
        check("first_data", 32'(bus_data), 32'hA5);

        // Simultaneous requests after reset go to requester 1; handover through TURN.
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 1, 1, 8'h11, 8'h3C);
        check("tie_gnt1", 32'(gnt1), 32'd1);
        step(0, 0, 0, 0, 1, 8'h11, 8'h3C);
        check("turn_sel", 32'(sel), 32'd0);
        check("turn_gnt2", 32'(gnt2), 32'd0);
        step(0, 0, 0, 0, 1, 8'h11, 8'h3C);
        check("handover_data", 32'(bus_data), 32'h3C);

        // Idle fill pattern, then a request overrides it.
        step(0, 0, 1, 0, 0, 8'h11, 8'h3C);
        step(0, 0, 1, 0, 0, 8'h11, 8'h3C);
        check("fill_data", 32'(bus_data), 32'hFF);
        check("fill_valid", 32'(bus_valid), 32'd0);
        step(0, 0, 1, 0, 1, 8'h11, 8'h5A);
        check("fill_ignored_sel", 32'(sel), 32'd2);

        // Flush during GRANT2, re-grant the cycle after.
        step(0, 1, 1, 0, 1, 8'h11, 8'h5A);
        check("flush_gnt2", 32'(gnt2), 32'd0);
        step(0, 0, 0, 0, 1, 8'h11, 8'h5A);
        check("regrant_gnt2", 32'(gnt2), 32'd1);

        // Reset during GRANT1; tie afterwards still favours requester 1.
        step(0, 0, 0, 0, 0, 8'h22, 8'h33);
        step(0, 0, 0, 1, 0, 8'h22, 8'h33);
        step(1, 0, 0, 1, 0, 8'h22, 8'h33);
        check("rst_mid_gnt1", 32'(gnt1), 32'd0);
        step(0, 0, 0, 1, 1, 8'h22, 8'h33);
        check("post_rst_tie", 32'(gnt1), 32'd1);

        // Long contention: timeout alternation when enabled, otherwise requester 1 keeps the bus.
        for (int i = 0; i < 3 * MAX_HOLD + 6; i++) begin
            step(0, 0, 0, 1, 1, 8'(i), 8'(~i));
        end
        step(0, 0, 0, 0, 0, 8'h00, 8'h00);

        // Random traffic with sticky requests so grants last several cycles.
        q1 = 1'b0; q2 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            f  = ($urandom_range(0, 15) == 0);
            fo = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) q1 = ~q1;
            if ($urandom_range(0, 3) == 0) q2 = ~q2;
            step(r, f, fo, q1, q2, 8'($urandom), 8'($urandom));
        end

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
